// File: rtl/ball_paddle_game_ctrl_if.sv
// Playfield-side signals of the game-flow sequencer.
// The controller uses the master modport; the playfield/scoreboard side uses the slave modport.
interface ball_paddle_game_ctrl_if;
    logic       vsync;
    logic       fire;
    logic [8:0] ball_y;
    logic       brick_hit;
    logic       ball_reset;
    logic       ball_enable;
    logic       declives;
    logic       brick_wr_en;
    logic [6:0] brick_wr_addr;
    logic       brick_wr_data;
    logic [3:0] lives;
    logic [7:0] bricks_left;
    logic [2:0] state;
    logic       game_over;

    modport master (
        input  vsync, fire, ball_y, brick_hit,
        output ball_reset, ball_enable, declives, brick_wr_en, brick_wr_addr,
               brick_wr_data, lives, bricks_left, state, game_over
    );

    modport slave (
        output vsync, fire, ball_y, brick_hit,
        input  ball_reset, ball_enable, declives, brick_wr_en, brick_wr_addr,
               brick_wr_data, lives, bricks_left, state, game_over
    );
endinterface

// File: rtl/ball_paddle_game_ctrl.sv
// Game-flow sequencer: owns lives and brick count, refills the brick array,
// and holds, releases and re-serves the ball across attract/play/game-over.
module ball_paddle_game_ctrl #(
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned BRICK_COUNT  = 128,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned LOST_FRAMES  = 90,
    parameter int unsigned BALL_LOST_Y  = 240
) (
    input logic                     clk,
    input logic                     reset,
    ball_paddle_game_ctrl_if.master bus
);
    // state    | meaning
    // IDLE     | attract, waiting for fire
    // FILL     | writing 1s to every brick slot, one per clk
    // SERVE    | ball held at serve position for SERVE_FRAMES frames
    // PLAY     | ball moving, bricks and misses counted
    // LOST     | pause after a missed ball
    // GAMEOVER | no lives left, waiting for fire
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        SERVE    = 3'd2,
        PLAY     = 3'd3,
        LOST     = 3'd4,
        GAMEOVER = 3'd5
    } state_t;

    localparam logic [3:0] LIVES_INIT  = 4'(START_LIVES);
    localparam logic [7:0] BRICKS_INIT = 8'(BRICK_COUNT);
    localparam logic [6:0] LAST_ADDR   = 7'(BRICK_COUNT - 1);
    localparam logic [7:0] SERVE_LAST  = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] LOST_LAST   = 8'(LOST_FRAMES - 1);
    localparam logic [8:0] LOST_Y      = 9'(BALL_LOST_Y);

    state_t     st;
    logic       vsync_q, fire_q;
    logic [7:0] frame_cnt;
    logic [6:0] wr_addr;
    logic       wr_en;
    logic [3:0] lives_r;
    logic [7:0] bricks_r;
    logic       ball_reset_r, ball_enable_r, declives_r, game_over_r;
    logic       frame_tick, fire_press;

    assign frame_tick = bus.vsync & ~vsync_q;
    assign fire_press = bus.fire & ~fire_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st            <= IDLE;
            vsync_q       <= 1'b0;
            fire_q        <= 1'b0;
            frame_cnt     <= 8'd0;
            wr_addr       <= 7'd0;
            wr_en         <= 1'b0;
            lives_r       <= LIVES_INIT;
            bricks_r      <= 8'd0;
            ball_reset_r  <= 1'b0;
            ball_enable_r <= 1'b0;
            declives_r    <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            vsync_q      <= bus.vsync;
            fire_q       <= bus.fire;
            ball_reset_r <= 1'b0;
            declives_r   <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (fire_press) begin
                        st      <= FILL;
                        lives_r <= LIVES_INIT;
                        wr_en   <= 1'b1;
                        wr_addr <= 7'd0;
                    end
                end
                FILL: begin
                    if (wr_addr == LAST_ADDR) begin
                        st           <= SERVE;
                        wr_en        <= 1'b0;
                        wr_addr      <= 7'd0;
                        bricks_r     <= BRICKS_INIT;
                        frame_cnt    <= 8'd0;
                        ball_reset_r <= 1'b1;
                    end else begin
                        wr_addr <= wr_addr + 7'd1;
                    end
                end
                SERVE: begin
                    if (frame_tick) begin
                        if (frame_cnt == SERVE_LAST) begin
                            st            <= PLAY;
                            frame_cnt     <= 8'd0;
                            ball_enable_r <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                PLAY: begin
                    // Clearing the level takes priority over a miss in the same clk.
                    if (bus.brick_hit && bricks_r == 8'd1) begin
                        st            <= FILL;
                        bricks_r      <= 8'd0;
                        wr_en         <= 1'b1;
                        wr_addr       <= 7'd0;
                        ball_enable_r <= 1'b0;
                    end else begin
                        if (bus.brick_hit && bricks_r != 8'd0)
                            bricks_r <= bricks_r - 8'd1;
                        if (frame_tick && bus.ball_y >= LOST_Y) begin
                            st            <= LOST;
                            declives_r    <= 1'b1;
                            frame_cnt     <= 8'd0;
                            ball_enable_r <= 1'b0;
                            if (lives_r != 4'd0)
                                lives_r <= lives_r - 4'd1;
                        end
                    end
                end
                LOST: begin
                    if (frame_tick) begin
                        if (frame_cnt == LOST_LAST) begin
                            frame_cnt <= 8'd0;
                            if (lives_r == 4'd0) begin
                                st          <= GAMEOVER;
                                game_over_r <= 1'b1;
                            end else begin
                                st           <= SERVE;
                                ball_reset_r <= 1'b1;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                GAMEOVER: begin
                    if (fire_press) begin
                        st          <= FILL;
                        lives_r     <= LIVES_INIT;
                        game_over_r <= 1'b0;
                        wr_en       <= 1'b1;
                        wr_addr     <= 7'd0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.ball_reset    = ball_reset_r;
    assign bus.ball_enable   = ball_enable_r;
    assign bus.declives      = declives_r;
    assign bus.brick_wr_en   = wr_en;
    assign bus.brick_wr_addr = wr_addr;
    assign bus.brick_wr_data = wr_en;
    assign bus.lives         = lives_r;
    assign bus.bricks_left   = bricks_r;
    assign bus.state         = st;
    assign bus.game_over     = game_over_r;
endmodule

// File: tb/tb_ball_paddle_game_ctrl.sv
// Self-checking bench for ball_paddle_game_ctrl: randomized frame timing, ball
// positions and hit counts, checked against a rule-level model of lives and bricks.
`timescale 1ns/1ps
module tb_ball_paddle_game_ctrl;
    localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_SERVE = 3'd2,
                           S_PLAY = 3'd3, S_LOST = 3'd4, S_OVER = 3'd5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    ball_paddle_game_ctrl_if bus();

    ball_paddle_game_ctrl #(
        .START_LIVES(3), .BRICK_COUNT(128), .SERVE_FRAMES(60),
        .LOST_FRAMES(90), .BALL_LOST_Y(240)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_lives = 3;
    int m_bricks = 0;

    // Running tallies of output activity, sampled on the falling edge.
    int n_wr = 0, n_addr_bad = 0, n_ball_reset = 0, n_declives = 0;
    logic       prev_wr = 1'b0;
    logic [6:0] prev_addr = 7'd0;
    always @(negedge clk) begin
        if (bus.brick_wr_en === 1'b1) begin
            n_wr++;
            if (bus.brick_wr_addr !== ((prev_wr === 1'b1) ? prev_addr + 7'd1 : 7'd0) ||
                bus.brick_wr_data !== 1'b1)
                n_addr_bad++;
        end
        if (bus.ball_reset === 1'b1) n_ball_reset++;
        if (bus.declives === 1'b1) n_declives++;
        prev_wr   = bus.brick_wr_en;
        prev_addr = bus.brick_wr_addr;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame();
        bus.vsync = 1'b1;
        tick($urandom_range(1, 3));
        bus.vsync = 1'b0;
        tick($urandom_range(2, 4));
    endtask

    task automatic press();
        bus.fire = 1'b1;
        tick();
        bus.fire = 1'b0;
        tick();
    endtask

    task automatic hit();
        bus.brick_hit = 1'b1;
        tick();
        bus.brick_hit = 1'b0;
        tick();
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.state === target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.vsync = 1'b0; bus.fire = 1'b0; bus.ball_y = 9'd0; bus.brick_hit = 1'b0;
        tick(3);
        m_lives = 3; m_bricks = 0;
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", bus.state, S_IDLE); end
        checks++; if (bus.lives !== 4'(m_lives)) begin errors++; $display("FAIL reset_lives: got %0d want %0d", bus.lives, m_lives); end
        checks++; if (bus.bricks_left !== 8'd0) begin errors++; $display("FAIL reset_bricks: got %0d want 0", bus.bricks_left); end
        checks++; if ({bus.brick_wr_en, bus.ball_enable, bus.game_over, bus.ball_reset, bus.declives} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got %b want 00000",
                {bus.brick_wr_en, bus.ball_enable, bus.game_over, bus.ball_reset, bus.declives}); end
        reset = 1'b0;
        tick(3);
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL idle_hold: got %0d want %0d", bus.state, S_IDLE); end
    endtask

    task automatic test_fill();
        int wr0, bad0, br0;
        bit ok;
        wr0 = n_wr; bad0 = n_addr_bad; br0 = n_ball_reset;
        press();
        checks++; if (bus.state !== S_FILL) begin errors++; $display("FAIL fill_entry: got %0d want %0d", bus.state, S_FILL); end
        wait_state(S_SERVE, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fill_done: state %0d, want %0d within 300 clks", bus.state, S_SERVE); end
        tick(2);
        m_bricks = 128; m_lives = 3;
        checks++; if (n_wr - wr0 != 128) begin errors++; $display("FAIL fill_count: got %0d want 128", n_wr - wr0); end
        checks++; if (n_addr_bad != bad0) begin errors++; $display("FAIL fill_addr: got %0d bad writes want 0", n_addr_bad - bad0); end
        checks++; if (n_ball_reset - br0 != 1) begin errors++; $display("FAIL fill_ball_reset: got %0d pulses want 1", n_ball_reset - br0); end
        checks++; if (bus.bricks_left !== 8'(m_bricks)) begin errors++; $display("FAIL fill_bricks: got %0d want %0d", bus.bricks_left, m_bricks); end
        checks++; if (bus.lives !== 4'(m_lives)) begin errors++; $display("FAIL fill_lives: got %0d want %0d", bus.lives, m_lives); end
    endtask

    // From SERVE: 59 frames keep the ball held, the 60th releases it.
    task automatic go_play(input bit poke_fire);
        for (int f = 0; f < 59; f++) begin
            bus.ball_y = 9'($urandom_range(0, 239));
            frame();
            if (poke_fire && f == 30) press();
        end
        checks++; if (bus.state !== S_SERVE || bus.ball_enable !== 1'b0) begin
            errors++; $display("FAIL serve_hold: got state %0d en %b want %0d en 0", bus.state, bus.ball_enable, S_SERVE); end
        frame();
        checks++; if (bus.state !== S_PLAY || bus.ball_enable !== 1'b1) begin
            errors++; $display("FAIL serve_release: got state %0d en %b want %0d en 1", bus.state, bus.ball_enable, S_PLAY); end
    endtask

    task automatic test_serve();
        go_play(1'b1);
    endtask

    // From PLAY: some random play, then a miss and the full pause.
    task automatic lose_ball(input bit hold_fire);
        int k, d0, br0;
        k = $urandom_range(1, 8);
        if (k > m_bricks - 2) k = 0;
        for (int i = 0; i < k; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.ball_y = 9'($urandom_range(0, 239));
                frame();
            end
            hit();
            m_bricks--;
        end
        checks++; if (bus.state !== S_PLAY || bus.bricks_left !== 8'(m_bricks)) begin
            errors++; $display("FAIL play_hits: got state %0d bricks %0d want %0d bricks %0d", bus.state, bus.bricks_left, S_PLAY, m_bricks); end
        d0 = n_declives;
        bus.ball_y = 9'(240 + $urandom_range(0, 271));
        frame();
        bus.ball_y = 9'd0;
        m_lives--;
        checks++; if (bus.state !== S_LOST || bus.ball_enable !== 1'b0) begin
            errors++; $display("FAIL lost_entry: got state %0d en %b want %0d en 0", bus.state, bus.ball_enable, S_LOST); end
        checks++; if (n_declives - d0 != 1) begin errors++; $display("FAIL lost_declives: got %0d pulses want 1", n_declives - d0); end
        checks++; if (bus.lives !== 4'(m_lives)) begin errors++; $display("FAIL lost_lives: got %0d want %0d", bus.lives, m_lives); end
        br0 = n_ball_reset;
        for (int f = 0; f < 89; f++) frame();
        checks++; if (bus.state !== S_LOST) begin errors++; $display("FAIL lost_hold: got %0d want %0d", bus.state, S_LOST); end
        if (hold_fire) begin
            bus.fire = 1'b1;
            tick(2);
        end
        frame();
        if (m_lives == 0) begin
            checks++; if (bus.state !== S_OVER || bus.game_over !== 1'b1) begin
                errors++; $display("FAIL gameover_entry: got state %0d go %b want %0d go 1", bus.state, bus.game_over, S_OVER); end
        end else begin
            checks++; if (bus.state !== S_SERVE) begin errors++; $display("FAIL reserve: got %0d want %0d", bus.state, S_SERVE); end
        end
        checks++; if (n_ball_reset - br0 != ((m_lives == 0) ? 0 : 1)) begin
            errors++; $display("FAIL reserve_pulse: got %0d pulses want %0d", n_ball_reset - br0, (m_lives == 0) ? 0 : 1); end
        checks++; if (bus.bricks_left !== 8'(m_bricks)) begin errors++; $display("FAIL lost_bricks: got %0d want %0d", bus.bricks_left, m_bricks); end
    endtask

    task automatic test_lose();
        lose_ball(1'b0);
    endtask

    // Clear the level; the final hit lands on the same clk as a lost-ball frame tick.
    task automatic test_level_clear();
        int d0, wr0, bad0;
        bit ok;
        go_play(1'b0);
        d0 = n_declives;
        while (m_bricks > 1) begin
            hit();
            m_bricks--;
            checks++; if (bus.bricks_left !== 8'(m_bricks)) begin errors++; $display("FAIL clear_count: got %0d want %0d", bus.bricks_left, m_bricks); end
        end
        wr0 = n_wr; bad0 = n_addr_bad;
        bus.ball_y = 9'd300;
        bus.vsync = 1'b1;
        bus.brick_hit = 1'b1;
        tick();
        bus.brick_hit = 1'b0;
        m_bricks = 0;
        checks++; if (bus.state !== S_FILL || bus.bricks_left !== 8'd0) begin
            errors++; $display("FAIL clear_entry: got state %0d bricks %0d want %0d bricks 0", bus.state, bus.bricks_left, S_FILL); end
        bus.vsync = 1'b0;
        bus.ball_y = 9'd0;
        wait_state(S_SERVE, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clear_fill_done: state %0d, want %0d within 300 clks", bus.state, S_SERVE); end
        tick(2);
        m_bricks = 128;
        checks++; if (n_declives != d0) begin errors++; $display("FAIL clear_no_declives: got %0d pulses want 0", n_declives - d0); end
        checks++; if (bus.lives !== 4'(m_lives)) begin errors++; $display("FAIL clear_lives: got %0d want %0d", bus.lives, m_lives); end
        checks++; if (n_wr - wr0 != 128 || n_addr_bad != bad0) begin
            errors++; $display("FAIL clear_refill: got %0d writes %0d bad want 128 writes 0 bad", n_wr - wr0, n_addr_bad - bad0); end
        checks++; if (bus.bricks_left !== 8'(m_bricks)) begin errors++; $display("FAIL clear_bricks: got %0d want %0d", bus.bricks_left, m_bricks); end
    endtask

    task automatic test_gameover();
        bit ok;
        while (m_lives > 1) begin
            go_play(1'b0);
            lose_ball(1'b0);
        end
        go_play(1'b0);
        lose_ball(1'b1);
        tick(10);
        checks++; if (bus.state !== S_OVER || bus.game_over !== 1'b1 || bus.ball_enable !== 1'b0) begin
            errors++; $display("FAIL fire_held: got state %0d go %b en %b want %0d go 1 en 0", bus.state, bus.game_over, bus.ball_enable, S_OVER); end
        bus.fire = 1'b0;
        tick(2);
        checks++; if (bus.state !== S_OVER) begin errors++; $display("FAIL fire_release: got %0d want %0d", bus.state, S_OVER); end
        bus.fire = 1'b1;
        tick();
        m_lives = 3;
        checks++; if (bus.state !== S_FILL || bus.lives !== 4'(m_lives) || bus.game_over !== 1'b0) begin
            errors++; $display("FAIL restart: got state %0d lives %0d go %b want %0d lives %0d go 0", bus.state, bus.lives, bus.game_over, S_FILL, m_lives); end
        checks++; if (bus.bricks_left !== 8'(m_bricks)) begin errors++; $display("FAIL restart_bricks_kept: got %0d want %0d", bus.bricks_left, m_bricks); end
        bus.fire = 1'b0;
        wait_state(S_SERVE, 300, ok);
        m_bricks = 128;
        checks++; if (!ok || bus.bricks_left !== 8'(m_bricks)) begin
            errors++; $display("FAIL restart_fill: got state %0d bricks %0d want %0d bricks %0d", bus.state, bus.bricks_left, S_SERVE, m_bricks); end
    endtask

    task automatic test_reset_mid_fill();
        int wr0, bad0;
        bit ok;
        reset = 1'b1; tick(2); reset = 1'b0; tick(2);
        press();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.brick_wr_en === 1'b1 && bus.brick_wr_addr === 7'd50) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!ok) begin errors++; $display("FAIL midfill_reach: addr %0d, want 50 within 200 clks", bus.brick_wr_addr); end
        #2 reset = 1'b1;
        #1;
        m_lives = 3; m_bricks = 0;
        checks++; if (bus.state !== S_IDLE || bus.brick_wr_en !== 1'b0) begin
            errors++; $display("FAIL midfill_abort: got state %0d wr %b want %0d wr 0", bus.state, bus.brick_wr_en, S_IDLE); end
        checks++; if (bus.bricks_left !== 8'd0 || bus.lives !== 4'(m_lives)) begin
            errors++; $display("FAIL midfill_regs: got bricks %0d lives %0d want 0 and %0d", bus.bricks_left, bus.lives, m_lives); end
        tick(2);
        reset = 1'b0;
        tick(2);
        wr0 = n_wr; bad0 = n_addr_bad;
        press();
        wait_state(S_SERVE, 300, ok);
        tick(2);
        checks++; if (!ok || n_wr - wr0 != 128 || n_addr_bad != bad0) begin
            errors++; $display("FAIL midfill_restart: got state %0d writes %0d bad %0d want %0d 128 0", bus.state, n_wr - wr0, n_addr_bad - bad0, S_SERVE); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_serve();
        test_lose();
        test_level_clear();
        test_gameover();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation still running at 3 ms, want finished");
        $fatal(1, "timeout");
    end
endmodule
